// File: rtl/accelerator_tensor_float_transmitter.sv
// Streams an I x J x K tensor from word-addressed memory, one element per cycle,
// tagging each element with the I/J/K enable strobes expected by the tensor units.
module accelerator_tensor_float_transmitter #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_IN,
  input  logic [DATA_SIZE-1:0] BASE_ADDRESS_IN,
  output logic [DATA_SIZE-1:0] MEMORY_ADDRESS,
  output logic                 MEMORY_READ_ENABLE,
  input  logic [DATA_SIZE-1:0] MEMORY_DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 DATA_OUT_I_ENABLE,
  output logic                 DATA_OUT_J_ENABLE,
  output logic                 DATA_OUT_K_ENABLE
);

  typedef enum logic [1:0] {
    STARTER_STATE,
    READ_STATE,
    DRAIN_STATE,
    ENDER_STATE
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_SIZE-1:0]    size_i_q, size_i_d;
  logic [DATA_SIZE-1:0]    size_j_q, size_j_d;
  logic [DATA_SIZE-1:0]    size_k_q, size_k_d;
  logic [CONTROL_SIZE-1:0] i_q, i_d;
  logic [CONTROL_SIZE-1:0] j_q, j_d;
  logic [CONTROL_SIZE-1:0] k_q, k_d;
  logic [DATA_SIZE-1:0]    addr_q, addr_d;
  logic                    rd_en_q, rd_en_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic                    i_en_q, i_en_d;
  logic                    j_en_q, j_en_d;
  logic                    k_en_q, k_en_d;
  logic                    ready_q, ready_d;

  logic i_last_c, j_last_c, k_last_c, size_zero_c;

  // Index bounds use the latched sizes resized to the counter width.
  assign i_last_c = (i_q == CONTROL_SIZE'(size_i_q) - CONTROL_SIZE'(1));
  assign j_last_c = (j_q == CONTROL_SIZE'(size_j_q) - CONTROL_SIZE'(1));
  assign k_last_c = (k_q == CONTROL_SIZE'(size_k_q) - CONTROL_SIZE'(1));
  assign size_zero_c = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (SIZE_K_IN == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= STARTER_STATE;
      size_i_q <= '0;
      size_j_q <= '0;
      size_k_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      addr_q   <= '0;
      rd_en_q  <= 1'b0;
      data_q   <= '0;
      i_en_q   <= 1'b0;
      j_en_q   <= 1'b0;
      k_en_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      size_i_q <= size_i_d;
      size_j_q <= size_j_d;
      size_k_q <= size_k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      addr_q   <= addr_d;
      rd_en_q  <= rd_en_d;
      data_q   <= data_d;
      i_en_q   <= i_en_d;
      j_en_q   <= j_en_d;
      k_en_q   <= k_en_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    size_i_d = size_i_q;
    size_j_d = size_j_q;
    size_k_d = size_k_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    addr_d   = addr_q;
    rd_en_d  = 1'b0;
    data_d   = data_q;
    i_en_d   = 1'b0;
    j_en_d   = 1'b0;
    k_en_d   = 1'b0;
    ready_d  = 1'b0;

    // Memory answers the address presented this cycle; its indices are still in i/j/k_q.
    if (rd_en_q) begin
      data_d = MEMORY_DATA_IN;
      k_en_d = 1'b1;
      j_en_d = (k_q == '0);
      i_en_d = (k_q == '0) && (j_q == '0);
    end

    case (state_q)
      STARTER_STATE: begin
        if (START) begin
          size_i_d = SIZE_I_IN;
          size_j_d = SIZE_J_IN;
          size_k_d = SIZE_K_IN;
          addr_d   = BASE_ADDRESS_IN;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          if (size_zero_c) begin
            state_d = ENDER_STATE;
            ready_d = 1'b1;
          end else begin
            state_d = READ_STATE;
            rd_en_d = 1'b1;
          end
        end
      end
      READ_STATE: begin
        if (i_last_c && j_last_c && k_last_c) begin
          state_d = DRAIN_STATE;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + DATA_SIZE'(1);
          if (!k_last_c) begin
            k_d = k_q + CONTROL_SIZE'(1);
          end else begin
            k_d = '0;
            if (!j_last_c) begin
              j_d = j_q + CONTROL_SIZE'(1);
            end else begin
              j_d = '0;
              i_d = i_q + CONTROL_SIZE'(1);
            end
          end
        end
      end
      DRAIN_STATE: begin
        state_d = ENDER_STATE;
        ready_d = 1'b1;
      end
      ENDER_STATE: begin
        state_d = STARTER_STATE;
      end
      default: begin
        state_d = STARTER_STATE;
      end
    endcase
  end

  assign READY              = ready_q;
  assign MEMORY_ADDRESS     = addr_q;
  assign MEMORY_READ_ENABLE = rd_en_q;
  assign DATA_OUT           = data_q;
  assign DATA_OUT_I_ENABLE  = i_en_q;
  assign DATA_OUT_J_ENABLE  = j_en_q;
  assign DATA_OUT_K_ENABLE  = k_en_q;

endmodule

// File: tb/tb_accelerator_tensor_float_transmitter.sv
// Bench for the tensor transmitter: per-cycle expectations derived from the
// transfer size, base address and cycle number of each run.
module tb_accelerator_tensor_float_transmitter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        READY;
  logic [63:0] SIZE_I_IN, SIZE_J_IN, SIZE_K_IN, BASE_ADDRESS_IN;
  logic [63:0] MEMORY_ADDRESS;
  logic        MEMORY_READ_ENABLE;
  logic [63:0] MEMORY_DATA_IN;
  logic [63:0] DATA_OUT;
  logic        DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] salt = '0;
  logic [63:0] prev_last = '0;

  accelerator_tensor_float_transmitter #(.DATA_SIZE(64), .CONTROL_SIZE(64)) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY),
    .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN), .SIZE_K_IN(SIZE_K_IN),
    .BASE_ADDRESS_IN(BASE_ADDRESS_IN),
    .MEMORY_ADDRESS(MEMORY_ADDRESS), .MEMORY_READ_ENABLE(MEMORY_READ_ENABLE),
    .MEMORY_DATA_IN(MEMORY_DATA_IN), .DATA_OUT(DATA_OUT),
    .DATA_OUT_I_ENABLE(DATA_OUT_I_ENABLE), .DATA_OUT_J_ENABLE(DATA_OUT_J_ENABLE),
    .DATA_OUT_K_ENABLE(DATA_OUT_K_ENABLE)
  );

  always #5 CLK = ~CLK;

  // Memory contents: each word is its address XOR a per-run salt.
  assign MEMORY_DATA_IN = MEMORY_ADDRESS ^ salt;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_idle(input int cyc);
    chk("rst_ready", cyc, 64'(READY), 64'd0);
    chk("rst_rd_en", cyc, 64'(MEMORY_READ_ENABLE), 64'd0);
    chk("rst_addr", cyc, MEMORY_ADDRESS, 64'd0);
    chk("rst_data", cyc, DATA_OUT, 64'd0);
    chk("rst_enables", cyc, 64'({DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE}), 64'd0);
  endtask

  // One transfer, called at a falling edge; START is accepted at the next rising edge.
  task automatic run(input logic [63:0] si, input logic [63:0] sj, input logic [63:0] sk,
                     input logic [63:0] base, input int pulse_at, input int rst_at);
    longint unsigned n_el;
    int          ready_cyc;
    logic        zero;
    logic [63:0] last_data;
    longint unsigned n;
    logic        ev;
    logic [63:0] kk, jj;
    zero      = (si == 0) || (sj == 0) || (sk == 0);
    n_el      = zero ? 0 : si * sj * sk;
    ready_cyc = zero ? 1 : int'(n_el) + 2;
    last_data = prev_last;
    SIZE_I_IN = si; SIZE_J_IN = sj; SIZE_K_IN = sk; BASE_ADDRESS_IN = base;
    START = 1'b1;
    for (int c = 1; c <= ready_cyc + 1; c++) begin
      @(negedge CLK);
      START = (c == pulse_at);
      SIZE_I_IN = rnd64(); SIZE_J_IN = rnd64(); SIZE_K_IN = rnd64(); BASE_ADDRESS_IN = rnd64();
      chk("rd_en", c, 64'(MEMORY_READ_ENABLE), 64'(c <= int'(n_el)));
      if (c <= int'(n_el)) chk("addr", c, MEMORY_ADDRESS, base + 64'(c - 1));
      ev = (c >= 2) && (c <= int'(n_el) + 1);
      if (ev) begin
        n  = longint'(c - 2);
        kk = n % sk;
        jj = (n / sk) % sj;
        last_data = (base + n) ^ salt;
        chk("k_en", c, 64'(DATA_OUT_K_ENABLE), 64'd1);
        chk("j_en", c, 64'(DATA_OUT_J_ENABLE), 64'(kk == 0));
        chk("i_en", c, 64'(DATA_OUT_I_ENABLE), 64'(kk == 0 && jj == 0));
      end else begin
        chk("enables_idle", c, 64'({DATA_OUT_I_ENABLE, DATA_OUT_J_ENABLE, DATA_OUT_K_ENABLE}), 64'd0);
      end
      chk("data", c, DATA_OUT, last_data);
      chk("ready", c, 64'(READY), 64'(c == ready_cyc));
      if (c == rst_at) begin
        RST = 1'b1;
        START = 1'b0;
        #1 chk_idle(c);
        for (int r = 1; r <= 3; r++) begin
          @(negedge CLK);
          chk_idle(c + r);
        end
        RST = 1'b0;
        @(negedge CLK);
        chk_idle(c + 4);
        prev_last = '0;
        return;
      end
    end
    prev_last = last_data;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0;
    SIZE_I_IN = '0; SIZE_J_IN = '0; SIZE_K_IN = '0; BASE_ADDRESS_IN = '0;
    #2 chk_idle(0);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk_idle(0);

    // Directed runs: 2x2x2 identity memory, 1x1x1, zero extent, ignored STARTs.
    run(2, 2, 2, 64'h100, 0, 0);
    run(1, 1, 1, 64'h200, 0, 0);
    run(3, 0, 4, 64'h300, 0, 0);
    run(2, 2, 2, 64'h400, 4, 0);
    run(2, 2, 2, 64'h500, 10, 0);
    run(2, 2, 2, 64'h600, 0, 0);
    // Reset mid-transfer, then restart from base.
    salt = 64'h0123_4567_89ab_cdef;
    run(2, 3, 4, 64'h700, 0, 5);
    run(2, 3, 4, 64'h700, 0, 0);
    // Address wrap.
    run(1, 1, 4, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0);

    // Randomised shapes, bases and memory contents.
    for (int t = 0; t < 12; t++) begin
      salt = rnd64();
      run(64'($urandom_range(1, 3)), 64'($urandom_range(1, 3)), 64'($urandom_range(1, 3)),
          (t % 3 == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)) : rnd64(),
          (t % 4 == 1) ? int'($urandom_range(2, 6)) : 0, 0);
    end
    run(64'($urandom_range(1, 3)), 64'd0, 64'($urandom_range(1, 3)), rnd64(), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
